syst_collector: RTL and testbench

SYST_COLLECTOR -- requirements
Module: syst_collector

---
 rtl/syst_collector.sv | 147 ++++++++++++++
 tb/tb_syst_collector.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/syst_collector.sv
// rtl/syst_collector.sv - deskews skewed systolic column results into aligned frames and buffers them
// Purpose: column k of a frame arrives k cycles after column 0. Column k is delayed by
//   N_COLS-1-k enable-gated register stages so all columns of a frame line up. An aligned
//   frame is pushed into a 2-entry FIFO whose head register drives the output.
// Ports:
//   clk, arstn       clock, asynchronous active-low reset
//   enable           advances the deskew stages; aligned valid is ignored while low
//   psumm_i          column results, column k in bits [k*S_WIDTH +: S_WIDTH]
//   valid_psumm_i    per-column qualifier
//   data_o, valid_o  FIFO head frame and its valid
//   ready_i          downstream accept (transfer on valid_o && ready_i)
//   overflow_o       sticky: aligned frame dropped because the FIFO was full
//   align_err_o      sticky: only some aligned valids were high
//   frames_o         frames accepted into the FIFO (wraps)
module syst_collector #(
   parameter int N_COLS    = 4,
   parameter int S_WIDTH   = 32,
   parameter int CNT_WIDTH = 16
) (
   input  logic                        clk,
   input  logic                        arstn,
   input  logic                        enable,
   input  logic [N_COLS*S_WIDTH-1:0]   psumm_i,
   input  logic [N_COLS-1:0]           valid_psumm_i,
   output logic [N_COLS*S_WIDTH-1:0]   data_o,
   output logic                        valid_o,
   input  logic                        ready_i,
   output logic                        overflow_o,
   output logic                        align_err_o,
   output logic [CNT_WIDTH-1:0]        frames_o
);

   typedef enum logic [1:0] {EMPTY, ONE, FULL} fifo_state_t;

   logic [N_COLS*S_WIDTH-1:0] aligned_data;
   logic [N_COLS-1:0]         aligned_vld;

   for (genvar k = 0; k < N_COLS; k++) begin : g_col
      localparam int D = N_COLS - 1 - k;
      if (D == 0) begin : g_direct
         // Last column arrives last, so it needs no delay.
         assign aligned_data[k*S_WIDTH +: S_WIDTH] = psumm_i[k*S_WIDTH +: S_WIDTH];
         assign aligned_vld[k]                     = valid_psumm_i[k];
      end else begin : g_delay
         logic [S_WIDTH-1:0] sd [D];
         logic [D-1:0]       sv;
         always_ff @(posedge clk or negedge arstn) begin
            if (!arstn) begin
               for (int i = 0; i < D; i++) sd[i] <= '0;
               sv <= '0;
            end else if (enable) begin
               sd[0] <= psumm_i[k*S_WIDTH +: S_WIDTH];
               sv[0] <= valid_psumm_i[k];
               for (int i = 1; i < D; i++) begin
                  sd[i] <= sd[i-1];
                  sv[i] <= sv[i-1];
               end
            end
         end
         assign aligned_data[k*S_WIDTH +: S_WIDTH] = sd[D-1];
         assign aligned_vld[k]                     = sv[D-1];
      end
   end

   logic push;
   logic partial;
   logic pop;

   assign push    = enable && (&aligned_vld);
   assign partial = enable && (|aligned_vld) && !(&aligned_vld);

   fifo_state_t               state, state_nxt;
   logic [N_COLS*S_WIDTH-1:0] head, tail;
   logic                      ld_head_new, ld_head_tail, ld_tail, accept, drop;

   assign valid_o = (state != EMPTY);
   assign pop     = valid_o && ready_i;
   assign data_o  = head;

   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) state <= EMPTY;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt    = state;
      ld_head_new  = 1'b0;
      ld_head_tail = 1'b0;
      ld_tail      = 1'b0;
      accept       = 1'b0;
      drop         = 1'b0;
      case (state)
         EMPTY: begin
            if (push) begin
               state_nxt   = ONE;
               ld_head_new = 1'b1;
               accept      = 1'b1;
            end
         end
         ONE: begin
            if (push && !pop) begin
               state_nxt = FULL;
               ld_tail   = 1'b1;
               accept    = 1'b1;
            end else if (push && pop) begin
               // Head leaves while the new frame replaces it.
               ld_head_new = 1'b1;
               accept      = 1'b1;
            end else if (pop) begin
               state_nxt = EMPTY;
            end
         end
         FULL: begin
            if (pop) begin
               ld_head_tail = 1'b1;
               if (push) begin
                  ld_tail = 1'b1;
                  accept  = 1'b1;
               end else begin
                  state_nxt = ONE;
               end
            end else if (push) begin
               drop = 1'b1;
            end
         end
         default: state_nxt = EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         head        <= '0;
         tail        <= '0;
         overflow_o  <= 1'b0;
         align_err_o <= 1'b0;
         frames_o    <= '0;
      end else begin
         if (ld_head_new)       head <= aligned_data;
         else if (ld_head_tail) head <= tail;
         if (ld_tail)           tail <= aligned_data;
         if (drop)              overflow_o  <= 1'b1;
         if (partial)           align_err_o <= 1'b1;
         if (accept)            frames_o    <= frames_o + CNT_WIDTH'(1);
      end
   end

endmodule

// File: tb/tb_syst_collector.sv
// tb/tb_syst_collector.sv - randomized self-checking bench for syst_collector
module tb_syst_collector;
   localparam int N  = 4;
   localparam int W  = 32;
   localparam int CW = 16;

   logic           clk = 1'b0;
   logic           arstn = 1'b0;
   logic           enable = 1'b0;
   logic [N*W-1:0] psumm_i = '0;
   logic [N-1:0]   valid_psumm_i = '0;
   logic [N*W-1:0] data_o;
   logic           valid_o;
   logic           ready_i = 1'b0;
   logic           overflow_o;
   logic           align_err_o;
   logic [CW-1:0]  frames_o;

   syst_collector #(.N_COLS(N), .S_WIDTH(W), .CNT_WIDTH(CW)) dut (
      .clk(clk), .arstn(arstn), .enable(enable), .psumm_i(psumm_i),
      .valid_psumm_i(valid_psumm_i), .data_o(data_o), .valid_o(valid_o),
      .ready_i(ready_i), .overflow_o(overflow_o), .align_err_o(align_err_o),
      .frames_o(frames_o)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic check_eq(input string tag, input logic [N*W-1:0] got, input logic [N*W-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Upstream schedule, indexed by enabled-cycle count so upstream freezes with enable.
   logic [N-1:0]   sch_v [64];
   logic [N*W-1:0] sch_d [64];
   int             en_cnt = 0;

   // Reference model: history of enabled-cycle inputs since reset, and the output buffer.
   typedef struct packed {
      logic [N-1:0]   v;
      logic [N*W-1:0] d;
   } ent_t;
   ent_t           hist[$];
   logic [N*W-1:0] q[$];
   bit             m_ovf = 0;
   bit             m_err = 0;
   logic [CW-1:0]  m_cnt = '0;

   task automatic model_clear();
      hist.delete();
      q.delete();
      m_ovf = 0;
      m_err = 0;
      m_cnt = '0;
   endtask

   // Column k shown in an enabled cycle is what was presented N-1-k enabled cycles earlier.
   task automatic model_step();
      logic [N-1:0]   av = '0;
      logic [N*W-1:0] ad = '0;
      bit             do_push = 0;
      bit             do_pop;
      int             sz;
      if (enable) begin
         ent_t e;
         e.v = valid_psumm_i;
         e.d = psumm_i;
         hist.push_back(e);
         if (hist.size() > N) void'(hist.pop_front());
         for (int k = 0; k < N; k++) begin
            int idx = hist.size() - 1 - (N - 1 - k);
            if (idx >= 0) begin
               av[k] = hist[idx].v[k];
               ad[k*W +: W] = hist[idx].d[k*W +: W];
            end
         end
         if (av == {N{1'b1}}) do_push = 1;
         else if (av != '0) m_err = 1;
      end
      sz = q.size();
      do_pop = (sz > 0) && ready_i;
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
         if (sz == 2 && !do_pop) m_ovf = 1;
         else begin
            q.push_back(ad);
            m_cnt = m_cnt + 1'b1;
         end
      end
   endtask

   task automatic compare_all();
      check_eq("valid_o", N*W'(valid_o), N*W'(q.size() > 0));
      if (q.size() > 0) check_eq("data_o", data_o, q[0]);
      check_eq("overflow_o", N*W'(overflow_o), N*W'(m_ovf));
      check_eq("align_err_o", N*W'(align_err_o), N*W'(m_err));
      check_eq("frames_o", N*W'(frames_o), N*W'(m_cnt));
   endtask

   task automatic schedule_frame(input bit fixed, input bit skew_err);
      int late = skew_err ? $urandom_range(N-1, 0) : -1;
      for (int k = 0; k < N; k++) begin
         int s = (en_cnt + k + ((k == late) ? 1 : 0)) % 64;
         sch_v[s][k] = 1'b1;
         sch_d[s][k*W +: W] = fixed ? W'(100 + k) : W'($urandom);
      end
   endtask

   task automatic step(input bit en, input bit rdy);
      @(negedge clk);
      compare_all();
      arstn   = 1'b1;
      enable  = en;
      ready_i = rdy;
      if (en) begin
         int s = en_cnt % 64;
         valid_psumm_i = sch_v[s];
         psumm_i       = sch_d[s];
         sch_v[s]      = '0;
         sch_d[s]      = '0;
         en_cnt++;
      end else begin
         valid_psumm_i = N'($urandom);
         psumm_i       = {$urandom, $urandom, $urandom, $urandom};
      end
      model_step();
   endtask

   task automatic apply_reset();
      @(negedge clk);
      arstn = 1'b0;
      #1;
      check_eq("rst valid_o", N*W'(valid_o), '0);
      check_eq("rst data_o", data_o, '0);
      check_eq("rst overflow_o", N*W'(overflow_o), '0);
      check_eq("rst align_err_o", N*W'(align_err_o), '0);
      check_eq("rst frames_o", N*W'(frames_o), '0);
      model_clear();
   endtask

   initial begin
      int rdy_hold = 0;
      bit rdy = 1;
      for (int i = 0; i < 64; i++) begin
         sch_v[i] = '0;
         sch_d[i] = '0;
      end

      apply_reset();

      // Single frame right after release: output exactly N cycles after column 0.
      schedule_frame(1, 0);
      repeat (N + 1) step(1, 1);
      check_eq("single valid_o", N*W'(valid_o), N*W'(1));
      check_eq("single data_o", data_o, {32'd103, 32'd102, 32'd101, 32'd100});
      check_eq("single frames_o", N*W'(frames_o), N*W'(1));
      step(1, 1);
      check_eq("single one-shot", N*W'(valid_o), '0);

      for (int cyc = 0; cyc < 3000; cyc++) begin
         bit en = ($urandom_range(7, 0) != 0);
         if (rdy_hold == 0) begin
            rdy = ($urandom_range(2, 0) != 0);
            rdy_hold = $urandom_range(12, 1);
         end
         rdy_hold--;
         if ($urandom_range(399, 0) == 0) apply_reset();
         if (en && $urandom_range(2, 0) == 0) schedule_frame(0, $urandom_range(15, 0) == 0);
         step(en, rdy);
      end

      @(negedge clk);
      compare_all();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
